mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe.sv | 154 +++++++++++++++
 tb/tb_mem_wb_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a one-entry skid buffer.
// Clears write-enable on writes to register zero and counts them.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 32,
  parameter int WE_BIT = 20,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] d2_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [CTRL_W-1:0] c_m_w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] d2_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [CTRL_W-1:0] c_m_w_out,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_d2_q, main_d2_d;
  logic [RD_W-1:0]   main_rd_q, main_rd_d;
  logic [CTRL_W-1:0] main_c_q, main_c_d;
  logic [DATA_W-1:0] skid_d2_q, skid_d2_d;
  logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
  logic [CTRL_W-1:0] skid_c_q, skid_c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              pop;
  logic              squash;
  logic [CTRL_W-1:0] cap_c;

  assign in_ready  = (state_q != S_SKID);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign squash    = c_m_w_in[WE_BIT] & (rd_in == '0);

  assign d2_out     = main_d2_q;
  assign rd_out     = main_rd_q;
  assign c_m_w_out  = main_c_q;
  assign squash_cnt = cnt_q;

  // Captured control word with write-enable dropped for x0 targets
  always_comb begin
    cap_c = c_m_w_in;
    if (squash) cap_c[WE_BIT] = 1'b0;
  end

  // Saturating count of squashed captures; flushed input never counts
  always_comb begin
    cnt_d = cnt_q;
    if (accept && squash && !flush && (cnt_q != '1))
      cnt_d = cnt_q + CNT_ONE;
  end

  // Occupancy FSM and main/skid register next-state
  always_comb begin
    state_d   = state_q;
    main_d2_d = main_d2_q;
    main_rd_d = main_rd_q;
    main_c_d  = main_c_q;
    skid_d2_d = skid_d2_q;
    skid_rd_d = skid_rd_q;
    skid_c_d  = skid_c_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d   = S_FULL;
          main_d2_d = d2_in;
          main_rd_d = rd_in;
          main_c_d  = cap_c;
        end
      end
      S_FULL: begin
        if (accept && pop) begin
          main_d2_d = d2_in;
          main_rd_d = rd_in;
          main_c_d  = cap_c;
        end else if (accept) begin
          state_d   = S_SKID;
          skid_d2_d = d2_in;
          skid_rd_d = rd_in;
          skid_c_d  = cap_c;
        end else if (pop) begin
          state_d   = S_EMPTY;
          main_d2_d = '0;
          main_rd_d = '0;
          main_c_d  = '0;
        end
      end
      S_SKID: begin
        if (pop) begin
          state_d   = S_FULL;
          main_d2_d = skid_d2_q;
          main_rd_d = skid_rd_q;
          main_c_d  = skid_c_q;
          skid_d2_d = '0;
          skid_rd_d = '0;
          skid_c_d  = '0;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    if (flush) begin
      state_d   = S_EMPTY;
      main_d2_d = '0;
      main_rd_d = '0;
      main_c_d  = '0;
      skid_d2_d = '0;
      skid_rd_d = '0;
      skid_c_d  = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      main_d2_q <= '0;
      main_rd_q <= '0;
      main_c_q  <= '0;
      skid_d2_q <= '0;
      skid_rd_q <= '0;
      skid_c_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      main_d2_q <= main_d2_d;
      main_rd_q <= main_rd_d;
      main_c_q  <= main_c_d;
      skid_d2_q <= skid_d2_d;
      skid_rd_q <= skid_rd_d;
      skid_c_q  <= skid_c_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: queue model plus directed literal checks.
// A second instance with a 2-bit counter covers saturation.
module tb_mem_wb_pipe;

  localparam int WB = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] d2_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] c_m_w_in = '0;

  logic        in_ready, out_valid;
  logic [31:0] d2_out, c_m_w_out;
  logic [4:0]  rd_out;
  logic [15:0] squash_cnt;

  logic        in_ready2, out_valid2;
  logic [31:0] d2_out2, c_m_w_out2;
  logic [4:0]  rd_out2;
  logic [1:0]  squash_cnt2;

  mem_wb_pipe dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .d2_in(d2_in), .rd_in(rd_in), .c_m_w_in(c_m_w_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .d2_out(d2_out), .rd_out(rd_out), .c_m_w_out(c_m_w_out),
    .squash_cnt(squash_cnt)
  );

  mem_wb_pipe #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .d2_in(d2_in), .rd_in(rd_in), .c_m_w_in(c_m_w_in),
    .out_valid(out_valid2), .out_ready(out_ready),
    .d2_out(d2_out2), .rd_out(rd_out2), .c_m_w_out(c_m_w_out2),
    .squash_cnt(squash_cnt2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
    logic [31:0] c;
  } ent_t;

  ent_t        mq[$];
  int unsigned mcnt;
  int unsigned mcnt2;
  bit          mon = 1'b0;
  int          checks = 0;
  int          failures = 0;
  ent_t        hd;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // One clock: drive inputs, then advance the queue model at the edge
  task automatic cyc(input logic iv, input logic [31:0] d,
                     input logic [4:0] rd, input logic [31:0] c,
                     input logic ordy, input logic fl, input logic rs);
    ent_t e;
    bit   acc, pp;
    @(negedge clock);
    #1;
    in_valid  = iv;
    d2_in     = d;
    rd_in     = rd;
    c_m_w_in  = c;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clock);
    if (rs) begin
      mq.delete();
      mcnt  = 0;
      mcnt2 = 0;
      mon   = 1'b1;
    end else if (fl) begin
      mq.delete();
    end else begin
      acc = iv && (mq.size() < 2);
      pp  = ordy && (mq.size() > 0);
      if (pp) void'(mq.pop_front());
      if (acc) begin
        e.d  = d;
        e.rd = rd;
        e.c  = c;
        if (c[WB] && rd == 5'd0) begin
          e.c[WB] = 1'b0;
          if (mcnt < 65535) mcnt++;
          if (mcnt2 < 3) mcnt2++;
        end
        mq.push_back(e);
      end
    end
    #1;
  endtask

  // Compare DUT outputs against the model every cycle
  always @(negedge clock) begin
    if (mon) begin
      hd = (mq.size() > 0) ? mq[0] : '0;
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("d2_out", 64'(d2_out), 64'(hd.d));
      chk("rd_out", 64'(rd_out), 64'(hd.rd));
      chk("c_m_w_out", 64'(c_m_w_out), 64'(hd.c));
      chk("squash_cnt", 64'(squash_cnt), 64'(mcnt));
      chk("squash_cnt2", 64'(squash_cnt2), 64'(mcnt2));
    end
  end

  int e2 [4] = '{1, 2, 3, 3};
  int e1 [4] = '{1, 2, 3, 4};

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d2", 64'(d2_out), 64'd0);
    chk("rst_rd", 64'(rd_out), 64'd0);
    chk("rst_c", 64'(c_m_w_out), 64'd0);
    chk("rst_cnt", 64'(squash_cnt), 64'd0);

    cyc(1, 32'hDEADBEEF, 5, 32'h0010_0000, 1, 0, 0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_d2", 64'(d2_out), 64'hDEADBEEF);
    chk("t1_rd", 64'(rd_out), 64'd5);
    chk("t1_c", 64'(c_m_w_out), 64'h0010_0000);
    chk("t1_cnt", 64'(squash_cnt), 64'd0);

    cyc(1, 32'h11, 0, 32'hFFFF_FFFF, 1, 0, 0);
    chk("sq_c", 64'(c_m_w_out), 64'hFFEF_FFFF);
    chk("sq_cnt", 64'(squash_cnt), 64'd1);
    cyc(1, 32'h22, 0, 32'h0000_000F, 1, 0, 0);
    chk("nosq_c", 64'(c_m_w_out), 64'h0000_000F);
    chk("nosq_cnt", 64'(squash_cnt), 64'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_d2", 64'(d2_out), 64'd0);

    cyc(1, 32'hA, 1, 32'h1, 0, 0, 0);
    cyc(1, 32'hB, 2, 32'h2, 0, 0, 0);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_head", 64'(d2_out), 64'hA);
    cyc(1, 32'hC, 3, 32'h3, 0, 0, 0);
    chk("held_head", 64'(d2_out), 64'hA);
    chk("held_in_ready", 64'(in_ready), 64'd0);
    cyc(1, 32'hC, 3, 32'h3, 1, 0, 0);
    chk("ord_b", 64'(d2_out), 64'hB);
    chk("ord_b_rd", 64'(rd_out), 64'd2);
    cyc(1, 32'hC, 3, 32'h3, 1, 0, 0);
    chk("ord_c", 64'(d2_out), 64'hC);
    chk("ord_c_rd", 64'(rd_out), 64'd3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("ord_empty", 64'(out_valid), 64'd0);

    cyc(1, 32'h66, 7, 32'h0010_0000, 0, 0, 0);
    cyc(1, 32'h77, 0, 32'h0010_0000, 0, 0, 0);
    chk("pre_fl_cnt", 64'(squash_cnt), 64'd2);
    cyc(1, 32'h88, 0, 32'hFFFF_FFFF, 0, 1, 0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_d2", 64'(d2_out), 64'd0);
    chk("fl_rd", 64'(rd_out), 64'd0);
    chk("fl_c", 64'(c_m_w_out), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_cnt", 64'(squash_cnt), 64'd2);

    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'(k), 0, 32'h0010_0000, 1, 0, 0);
      chk("sat_cnt2", 64'(squash_cnt2), 64'(e2[k]));
      chk("sat_cnt", 64'(squash_cnt), 64'(e1[k]));
    end

    cyc(1, 32'h55, 9, 32'h1, 0, 1, 1);
    chk("rf_in_ready", 64'(in_ready), 64'd1);
    chk("rf_valid", 64'(out_valid), 64'd0);
    chk("rf_d2", 64'(d2_out), 64'd0);
    chk("rf_rd", 64'(rd_out), 64'd0);
    chk("rf_c", 64'(c_m_w_out), 64'd0);
    chk("rf_cnt", 64'(squash_cnt), 64'd0);
    chk("rf_cnt2", 64'(squash_cnt2), 64'd0);

    for (int k = 0; k < 80; k++) begin
      cyc(1'($urandom_range(0, 1)), $urandom,
          5'($urandom_range(0, 3)),
          (($urandom_range(0, 1) != 0) ? 32'h0010_0000 : 32'h0) | 32'($urandom_range(0, 255)),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 31) == 0));
    end

    @(negedge clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
